// File: rtl/stg_mo_pkg.sv
// Shared MO-stage definitions: opcode constants, memory classes, FSM states,
// the registered pass-through bundle and the opcode-to-class decode.
package stg_mo_pkg;

  localparam int SIZE_ADDR    = 48;
  localparam int SIZE_DATA    = 24;
  localparam int SIZE_OPC     = 8;
  localparam int SIZE_TGT_GP  = 4;
  localparam int SIZE_TGT_SR  = 2;
  localparam int SIZE_TGT_AR  = 2;
  localparam int SIZE_CR_ADDR = 4;

  localparam logic [SIZE_OPC-1:0] OPC_NOP  = 8'h00;
  localparam logic [SIZE_OPC-1:0] OPC_ADD  = 8'h01;
  localparam logic [SIZE_OPC-1:0] OPC_SUB  = 8'h02;
  localparam logic [SIZE_OPC-1:0] OPC_LD24 = 8'h20;
  localparam logic [SIZE_OPC-1:0] OPC_ST24 = 8'h21;
  localparam logic [SIZE_OPC-1:0] OPC_LD48 = 8'h22;
  localparam logic [SIZE_OPC-1:0] OPC_ST48 = 8'h23;

  typedef enum logic [2:0] {
    MC_NONE = 3'd0,
    MC_LD24 = 3'd1,
    MC_ST24 = 3'd2,
    MC_LD48 = 3'd3,
    MC_ST48 = 3'd4
  } mem_class_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HI   = 1'b1
  } mo_state_e;

  // Fields that are carried toward WB untouched by the memory access.
  typedef struct packed {
    logic [SIZE_ADDR-1:0]    pc;
    logic [SIZE_DATA-1:0]    instr;
    logic [SIZE_OPC-1:0]     opc;
    logic [SIZE_TGT_GP-1:0]  tgt_gp;
    logic                    tgt_gp_we;
    logic [SIZE_TGT_SR-1:0]  tgt_sr;
    logic                    tgt_sr_we;
    logic [SIZE_TGT_AR-1:0]  tgt_ar;
    logic                    tgt_ar_we;
    logic [SIZE_CR_ADDR-1:0] cr_write_addr;
    logic                    cr_we_base;
    logic [SIZE_ADDR-1:0]    cr_base;
    logic                    cr_we_len;
    logic [SIZE_ADDR-1:0]    cr_len;
    logic                    cr_we_cur;
    logic [SIZE_ADDR-1:0]    cr_cur;
    logic                    cr_we_perms;
    logic [SIZE_DATA-1:0]    cr_perms;
    logic                    cr_we_attr;
    logic [SIZE_DATA-1:0]    cr_attr;
    logic                    cr_we_tag;
    logic                    cr_tag;
  } mo_pt_t;

  function automatic mem_class_e opc_to_mc(input logic [SIZE_OPC-1:0] opc);
    case (opc)
      OPC_LD24: return MC_LD24;
      OPC_ST24: return MC_ST24;
      OPC_LD48: return MC_LD48;
      OPC_ST48: return MC_ST48;
      default:  return MC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/stg_mo_word_merge.sv
// Combinational join of two memory words into a wide value (loads) and split
// of a wide value into the words stored at addr and addr+1 (stores).
module stg_mo_word_merge
  import stg_mo_pkg::*;
#(
  parameter int P_LO_FIRST = 1
) (
  input  logic [SIZE_DATA-1:0] iw_first,
  input  logic [SIZE_DATA-1:0] iw_second,
  output logic [SIZE_ADDR-1:0] ow_merged,
  input  logic [SIZE_ADDR-1:0] iw_wide,
  output logic [SIZE_DATA-1:0] ow_first,
  output logic [SIZE_DATA-1:0] ow_second
);

  // "first" is always the word at addr, "second" the word at addr+1.
  if (P_LO_FIRST != 0) begin : g_lo_first
    assign ow_merged = {iw_second, iw_first};
    assign ow_first  = iw_wide[SIZE_DATA-1:0];
    assign ow_second = iw_wide[SIZE_ADDR-1:SIZE_DATA];
  end else begin : g_hi_first
    assign ow_merged = {iw_first, iw_second};
    assign ow_first  = iw_wide[SIZE_ADDR-1:SIZE_DATA];
    assign ow_second = iw_wide[SIZE_DATA-1:0];
  end

endmodule

// File: rtl/stg_mo.sv
// Memory-operation pipeline stage: 24-bit accesses in one cycle, 48-bit in two
// with a one-cycle stall. Optional EX bypass outputs under STG_MO_FWD_EN.
module stg_mo
  import stg_mo_pkg::*;
#(
  parameter int P_LO_FIRST = 1
) (
  input  logic                    iw_clk,
  input  logic                    iw_rst,
  input  logic [SIZE_ADDR-1:0]    iw_pc,
  output logic [SIZE_ADDR-1:0]    ow_pc,
  input  logic [SIZE_DATA-1:0]    iw_instr,
  output logic [SIZE_DATA-1:0]    ow_instr,
  input  logic [SIZE_OPC-1:0]     iw_opc,
  output logic [SIZE_OPC-1:0]     ow_opc,
  input  logic [SIZE_TGT_GP-1:0]  iw_tgt_gp,
  input  logic                    iw_tgt_gp_we,
  output logic [SIZE_TGT_GP-1:0]  ow_tgt_gp,
  output logic                    ow_tgt_gp_we,
  input  logic [SIZE_TGT_SR-1:0]  iw_tgt_sr,
  input  logic                    iw_tgt_sr_we,
  output logic [SIZE_TGT_SR-1:0]  ow_tgt_sr,
  output logic                    ow_tgt_sr_we,
  input  logic [SIZE_TGT_AR-1:0]  iw_tgt_ar,
  input  logic                    iw_tgt_ar_we,
  output logic [SIZE_TGT_AR-1:0]  ow_tgt_ar,
  output logic                    ow_tgt_ar_we,
  input  logic                    iw_mem_mp,
  input  logic [SIZE_ADDR-1:0]    iw_addr,
  input  logic [SIZE_DATA-1:0]    iw_result,
  output logic [SIZE_DATA-1:0]    ow_result,
  input  logic [SIZE_ADDR-1:0]    iw_sr_result,
  output logic [SIZE_ADDR-1:0]    ow_sr_result,
  input  logic [SIZE_ADDR-1:0]    iw_ar_result,
  output logic [SIZE_ADDR-1:0]    ow_ar_result,
  input  logic [SIZE_DATA-1:0]    iw_mem_rdata0,
  input  logic [SIZE_DATA-1:0]    iw_mem_rdata1,
  output logic                    ow_mem_we0,
  output logic                    ow_mem_we1,
  output logic [SIZE_DATA-1:0]    ow_mem_wdata,
  output logic                    ow_addr_ovr_en,
  output logic [SIZE_ADDR-1:0]    ow_addr_ovr,
  output logic                    ow_stall,
  input  logic [SIZE_CR_ADDR-1:0] iw_cr_write_addr,
  input  logic                    iw_cr_we_base,
  input  logic [SIZE_ADDR-1:0]    iw_cr_base,
  input  logic                    iw_cr_we_len,
  input  logic [SIZE_ADDR-1:0]    iw_cr_len,
  input  logic                    iw_cr_we_cur,
  input  logic [SIZE_ADDR-1:0]    iw_cr_cur,
  input  logic                    iw_cr_we_perms,
  input  logic [SIZE_DATA-1:0]    iw_cr_perms,
  input  logic                    iw_cr_we_attr,
  input  logic [SIZE_DATA-1:0]    iw_cr_attr,
  input  logic                    iw_cr_we_tag,
  input  logic                    iw_cr_tag,
  output logic [SIZE_CR_ADDR-1:0] ow_cr_write_addr,
  output logic                    ow_cr_we_base,
  output logic [SIZE_ADDR-1:0]    ow_cr_base,
  output logic                    ow_cr_we_len,
  output logic [SIZE_ADDR-1:0]    ow_cr_len,
  output logic                    ow_cr_we_cur,
  output logic [SIZE_ADDR-1:0]    ow_cr_cur,
  output logic                    ow_cr_we_perms,
  output logic [SIZE_DATA-1:0]    ow_cr_perms,
  output logic                    ow_cr_we_attr,
  output logic [SIZE_DATA-1:0]    ow_cr_attr,
  output logic                    ow_cr_we_tag,
  output logic                    ow_cr_tag
`ifdef STG_MO_FWD_EN
  ,
  output logic                    ow_fwd_valid,
  output logic [SIZE_ADDR-1:0]    ow_fwd_data
`endif
);

  mo_state_e            state_q, state_d;
  mem_class_e           mc;
  mo_pt_t               pt_in, pt_q, pt_d;
  logic [SIZE_DATA-1:0] half_q, half_d;
  logic [SIZE_DATA-1:0] result_q, result_d;
  logic [SIZE_ADDR-1:0] sr_result_q, sr_result_d;
  logic [SIZE_ADDR-1:0] ar_result_q, ar_result_d;
  logic [SIZE_DATA-1:0] rdata;
  logic [SIZE_ADDR-1:0] merged;
  logic [SIZE_DATA-1:0] st_first, st_second;
  logic                 wr_req, stall_req, ovr_req;
  logic [SIZE_DATA-1:0] wdata;

  assign mc    = opc_to_mc(iw_opc);
  assign rdata = iw_mem_mp ? iw_mem_rdata1 : iw_mem_rdata0;

  stg_mo_word_merge #(
    .P_LO_FIRST(P_LO_FIRST)
  ) u_merge (
    .iw_first (half_q),
    .iw_second(rdata),
    .ow_merged(merged),
    .iw_wide  (iw_ar_result),
    .ow_first (st_first),
    .ow_second(st_second)
  );

  always_comb begin
    pt_in               = '0;
    pt_in.pc            = iw_pc;
    pt_in.instr         = iw_instr;
    pt_in.opc           = iw_opc;
    pt_in.tgt_gp        = iw_tgt_gp;
    pt_in.tgt_gp_we     = iw_tgt_gp_we;
    pt_in.tgt_sr        = iw_tgt_sr;
    pt_in.tgt_sr_we     = iw_tgt_sr_we;
    pt_in.tgt_ar        = iw_tgt_ar;
    pt_in.tgt_ar_we     = iw_tgt_ar_we;
    pt_in.cr_write_addr = iw_cr_write_addr;
    pt_in.cr_we_base    = iw_cr_we_base;
    pt_in.cr_base       = iw_cr_base;
    pt_in.cr_we_len     = iw_cr_we_len;
    pt_in.cr_len        = iw_cr_len;
    pt_in.cr_we_cur     = iw_cr_we_cur;
    pt_in.cr_cur        = iw_cr_cur;
    pt_in.cr_we_perms   = iw_cr_we_perms;
    pt_in.cr_perms      = iw_cr_perms;
    pt_in.cr_we_attr    = iw_cr_we_attr;
    pt_in.cr_attr       = iw_cr_attr;
    pt_in.cr_we_tag     = iw_cr_we_tag;
    pt_in.cr_tag        = iw_cr_tag;
  end

  always_comb begin
    state_d     = state_q;
    pt_d        = pt_q;
    half_d      = half_q;
    result_d    = result_q;
    sr_result_d = sr_result_q;
    ar_result_d = ar_result_q;
    wr_req      = 1'b0;
    wdata       = '0;
    stall_req   = 1'b0;
    ovr_req     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mc == MC_LD48 || mc == MC_ST48) begin
          // First word of a wide access; WB-facing registers hold this cycle.
          stall_req = 1'b1;
          ovr_req   = 1'b1;
          state_d   = S_HI;
          if (mc == MC_LD48) begin
            half_d = rdata;
          end else begin
            wr_req = 1'b1;
            wdata  = st_first;
          end
        end else begin
          pt_d        = pt_in;
          result_d    = (mc == MC_LD24) ? rdata : iw_result;
          sr_result_d = iw_sr_result;
          ar_result_d = iw_ar_result;
          if (mc == MC_ST24) begin
            wr_req = 1'b1;
            wdata  = iw_result;
          end
        end
      end
      S_HI: begin
        // iw_mem_mp has toggled, so rdata/we now target the overridden port.
        state_d     = S_IDLE;
        pt_d        = pt_in;
        result_d    = iw_result;
        sr_result_d = (mc == MC_LD48 && iw_tgt_sr_we) ? merged : iw_sr_result;
        ar_result_d = (mc == MC_LD48 && iw_tgt_ar_we) ? merged : iw_ar_result;
        if (mc == MC_ST48) begin
          wr_req = 1'b1;
          wdata  = st_second;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      state_q     <= S_IDLE;
      pt_q        <= '0;
      half_q      <= '0;
      result_q    <= '0;
      sr_result_q <= '0;
      ar_result_q <= '0;
    end else begin
      state_q     <= state_d;
      pt_q        <= pt_d;
      half_q      <= half_d;
      result_q    <= result_d;
      sr_result_q <= sr_result_d;
      ar_result_q <= ar_result_d;
    end
  end

  // Strobes are combinational, so reset must mask them directly.
  assign ow_mem_we0     = wr_req & ~iw_mem_mp & ~iw_rst;
  assign ow_mem_we1     = wr_req &  iw_mem_mp & ~iw_rst;
  assign ow_mem_wdata   = wdata;
  assign ow_stall       = stall_req & ~iw_rst;
  assign ow_addr_ovr_en = ovr_req & ~iw_rst;
  assign ow_addr_ovr    = iw_addr + SIZE_ADDR'(1);

  assign ow_pc            = pt_q.pc;
  assign ow_instr         = pt_q.instr;
  assign ow_opc           = pt_q.opc;
  assign ow_tgt_gp        = pt_q.tgt_gp;
  assign ow_tgt_gp_we     = pt_q.tgt_gp_we;
  assign ow_tgt_sr        = pt_q.tgt_sr;
  assign ow_tgt_sr_we     = pt_q.tgt_sr_we;
  assign ow_tgt_ar        = pt_q.tgt_ar;
  assign ow_tgt_ar_we     = pt_q.tgt_ar_we;
  assign ow_result        = result_q;
  assign ow_sr_result     = sr_result_q;
  assign ow_ar_result     = ar_result_q;
  assign ow_cr_write_addr = pt_q.cr_write_addr;
  assign ow_cr_we_base    = pt_q.cr_we_base;
  assign ow_cr_base       = pt_q.cr_base;
  assign ow_cr_we_len     = pt_q.cr_we_len;
  assign ow_cr_len        = pt_q.cr_len;
  assign ow_cr_we_cur     = pt_q.cr_we_cur;
  assign ow_cr_cur        = pt_q.cr_cur;
  assign ow_cr_we_perms   = pt_q.cr_we_perms;
  assign ow_cr_perms      = pt_q.cr_perms;
  assign ow_cr_we_attr    = pt_q.cr_we_attr;
  assign ow_cr_attr       = pt_q.cr_attr;
  assign ow_cr_we_tag     = pt_q.cr_we_tag;
  assign ow_cr_tag        = pt_q.cr_tag;

`ifdef STG_MO_FWD_EN
  assign ow_fwd_valid = ~iw_rst & (((state_q == S_IDLE) && (mc == MC_LD24)) ||
                                   ((state_q == S_HI) && (mc == MC_LD48)));
  assign ow_fwd_data  = (state_q == S_HI) ? merged
                                          : {{(SIZE_ADDR-SIZE_DATA){1'b0}}, rdata};
`endif

endmodule
